// File: rtl/sort_arbiter.sv
// Two-requester arbiter in front of a shared 8-entry sorter: grants ownership,
// forwards the owner's memory/start controls, and revokes idle owners via a watchdog.
module sort_arbiter #(
  parameter int WD_LIMIT = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req0_i,
  input  logic       req1_i,
  input  logic       wr0_i,
  input  logic       wr1_i,
  input  logic [2:0] addr0_i,
  input  logic [2:0] addr1_i,
  input  logic [7:0] din0_i,
  input  logic [7:0] din1_i,
  input  logic       start0_i,
  input  logic       start1_i,
  output logic       grant0_o,
  output logic       grant1_o,
  output logic       done0_o,
  output logic       done1_o,
  output logic       revoked0_o,
  output logic       revoked1_o,
  output logic [7:0] dout_o,
  output logic       s_nrst_o,
  output logic       s_start_o,
  output logic       s_wr_o,
  output logic [2:0] s_addr_o,
  output logic [7:0] s_din_o,
  input  logic [7:0] s_dout_i,
  input  logic       s_ready_i
);
  localparam int WDW = $clog2(WD_LIMIT + 1);
  localparam logic [WDW-1:0] WD_LAST = WDW'(WD_LIMIT - 1);

  typedef enum logic [2:0] {IDLE, GRANT, ACK, SORT, DRAIN} state_e;

  state_e         state_q, state_d;
  logic           owner_q, owner_d;
  logic           last_q, last_d;
  logic [WDW-1:0] wd_q, wd_d;

  logic       own_req, oth_req, own_wr, own_start;
  logic [2:0] own_addr;
  logic [7:0] own_din;

  assign own_req   = owner_q ? req1_i   : req0_i;
  assign oth_req   = owner_q ? req0_i   : req1_i;
  assign own_wr    = owner_q ? wr1_i    : wr0_i;
  assign own_start = owner_q ? start1_i : start0_i;
  assign own_addr  = owner_q ? addr1_i  : addr0_i;
  assign own_din   = owner_q ? din1_i   : din0_i;

  assign s_nrst_o = ~rst;
  assign dout_o   = s_dout_i;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    wd_d       = wd_q;
    grant0_o   = 1'b0;
    grant1_o   = 1'b0;
    done0_o    = 1'b0;
    done1_o    = 1'b0;
    revoked0_o = 1'b0;
    revoked1_o = 1'b0;
    s_start_o  = 1'b0;
    s_wr_o     = 1'b0;
    s_addr_o   = '0;
    s_din_o    = '0;
    if (state_q == GRANT || state_q == ACK || state_q == SORT) begin
      grant0_o = ~owner_q;
      grant1_o = owner_q;
    end
    case (state_q)
      IDLE: begin
        if (req0_i && req1_i) owner_d = ~last_q;
        else if (req1_i)      owner_d = 1'b1;
        else if (req0_i)      owner_d = 1'b0;
        if (req0_i || req1_i) begin
          state_d = GRANT;
          wd_d    = '0;
        end
      end
      GRANT: begin
        s_wr_o   = own_wr;
        s_addr_o = own_addr;
        s_din_o  = own_din;
        // Release beats revoke, revoke beats a new sort launch.
        if (!own_req) begin
          state_d = DRAIN;
          last_d  = owner_q;
          wd_d    = '0;
        end else if (oth_req && wd_q == WD_LAST) begin
          revoked0_o = ~owner_q;
          revoked1_o = owner_q;
          state_d    = DRAIN;
          last_d     = owner_q;
          wd_d       = '0;
        end else if (own_start && s_ready_i) begin
          s_start_o = 1'b1;
          s_wr_o    = 1'b0;
          state_d   = ACK;
          wd_d      = '0;
        end else begin
          wd_d = oth_req ? wd_q + 1'b1 : '0;
        end
      end
      ACK: begin
        wd_d = '0;
        if (!s_ready_i) state_d = SORT;
      end
      SORT: begin
        wd_d = '0;
        if (s_ready_i) begin
          done0_o = ~owner_q;
          done1_o = owner_q;
          state_d = GRANT;
        end
      end
      DRAIN:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
endmodule

// File: tb/tb_sort_arbiter.sv
// Directed bench for sort_arbiter with a behavioural 8-entry sorter model
// (registered read, busy window of programmable length after s_start).
module tb_sort_arbiter;
  logic       clk = 1'b0;
  logic       rst;
  logic       req0, req1, wr0, wr1, start0, start1;
  logic [2:0] addr0, addr1;
  logic [7:0] din0, din1;
  logic       grant0, grant1, done0, done1, revoked0, revoked1;
  logic [7:0] dout;
  logic       s_nrst, s_start, s_wr;
  logic [2:0] s_addr;
  logic [7:0] s_din;
  logic [7:0] s_dout;
  logic       s_ready;

  int checks = 0;
  int errors = 0;
  int lat    = 3;
  int cnt;

  typedef logic [7:0] arr_t [8];
  arr_t mem;

  always #5 clk = ~clk;

  sort_arbiter #(.WD_LIMIT(4)) dut (
    .clk(clk), .rst(rst),
    .req0_i(req0), .req1_i(req1), .wr0_i(wr0), .wr1_i(wr1),
    .addr0_i(addr0), .addr1_i(addr1), .din0_i(din0), .din1_i(din1),
    .start0_i(start0), .start1_i(start1),
    .grant0_o(grant0), .grant1_o(grant1), .done0_o(done0), .done1_o(done1),
    .revoked0_o(revoked0), .revoked1_o(revoked1), .dout_o(dout),
    .s_nrst_o(s_nrst), .s_start_o(s_start), .s_wr_o(s_wr),
    .s_addr_o(s_addr), .s_din_o(s_din), .s_dout_i(s_dout), .s_ready_i(s_ready)
  );

  function automatic arr_t sort8(input arr_t a);
    arr_t r = a;
    for (int i = 0; i < 8; i++)
      for (int j = 0; j < 7 - i; j++)
        if (r[j] > r[j+1]) begin
          logic [7:0] t = r[j];
          r[j] = r[j+1];
          r[j+1] = t;
        end
    return r;
  endfunction

  always @(posedge clk) begin
    if (!s_nrst) begin
      s_ready <= 1'b1;
      cnt     <= 0;
      s_dout  <= 8'h00;
    end else begin
      s_dout <= mem[s_addr];
      if (s_start) begin
        cnt     <= lat;
        s_ready <= 1'b0;
      end else if (cnt > 1) begin
        cnt <= cnt - 1;
      end else if (cnt == 1) begin
        cnt     <= 0;
        s_ready <= 1'b1;
        mem     <= sort8(mem);
      end
      if (s_wr) mem[s_addr] <= s_din;
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  typedef struct {
    logic wr0, wr1; logic [2:0] a0, a1; logic [7:0] d0, d1;
    logic ewr; logic [2:0] eaddr; logic [7:0] edin;
  } fwd_t;
  typedef struct { logic [2:0] addr; logic [7:0] din; } wr_t;

  fwd_t       fv[5];
  wr_t        wv[8];
  logic [7:0] rexp[8];

  initial begin
    int seen, bad;
    fv[0] = '{1'b0, 1'b1, 3'd3, 3'd3, 8'h00, 8'h5A, 1'b1, 3'd3, 8'h5A};
    fv[1] = '{1'b1, 1'b0, 3'd3, 3'd5, 8'hAA, 8'h11, 1'b0, 3'd5, 8'h11};
    fv[2] = '{1'b0, 1'b1, 3'd3, 3'd6, 8'hAA, 8'h22, 1'b1, 3'd6, 8'h22};
    fv[3] = '{1'b1, 1'b1, 3'd3, 3'd2, 8'hBB, 8'h33, 1'b1, 3'd2, 8'h33};
    fv[4] = '{1'b1, 1'b0, 3'd7, 3'd3, 8'hCC, 8'h44, 1'b0, 3'd3, 8'h44};
    wv[0] = '{3'd0, 8'd5}; wv[1] = '{3'd1, 8'd3}; wv[2] = '{3'd2, 8'd7}; wv[3] = '{3'd3, 8'd1};
    wv[4] = '{3'd4, 8'd0}; wv[5] = '{3'd5, 8'd6}; wv[6] = '{3'd6, 8'd2}; wv[7] = '{3'd7, 8'd4};
    for (int i = 0; i < 8; i++) rexp[i] = 8'(i);

    rst = 1'b1; req0 = 0; req1 = 0; wr0 = 0; wr1 = 0; start0 = 0; start1 = 0;
    addr0 = 0; addr1 = 0; din0 = 0; din1 = 0;
    cyc(); cyc();
    chk("reset grants", {grant0, grant1}, 0);
    chk("reset pulses", {done0, done1, revoked0, revoked1}, 0);
    chk("reset sorter ctl", {s_start, s_wr, s_addr, s_din}, 0);
    chk("reset s_nrst", s_nrst, 0);
    rst = 1'b0;
    #1 chk("s_nrst released", s_nrst, 1);

    // Tie after reset goes to requester 0; release passes through DRAIN and IDLE.
    req0 = 1; req1 = 1;
    #1 chk("idle no grant", {grant0, grant1}, 0);
    cyc(); chk("tie grant0", {grant0, grant1}, 2'b10);
    req0 = 0;
    cyc(); chk("drain grants", {grant0, grant1}, 0);
    cyc(); chk("idle grants", {grant0, grant1}, 0);
    cyc(); chk("handover grant1", {grant0, grant1}, 2'b01);

    // Owner 1 forwarding; requester 0 inputs must be ignored.
    for (int i = 0; i < 5; i++) begin
      wr0 = fv[i].wr0; wr1 = fv[i].wr1; addr0 = fv[i].a0; addr1 = fv[i].a1;
      din0 = fv[i].d0; din1 = fv[i].d1;
      #1;
      chk($sformatf("fwd%0d s_wr", i), s_wr, fv[i].ewr);
      chk($sformatf("fwd%0d s_addr", i), s_addr, fv[i].eaddr);
      chk($sformatf("fwd%0d s_din", i), s_din, fv[i].edin);
      cyc();
    end
    chk("mem3 untouched by wr0", mem[3], 8'h5A);
    chk("mem2 written by wr1", mem[2], 8'h33);
    wr0 = 0; wr1 = 0; req1 = 0;
    cyc(); cyc();

    // Owner 0 loads, sorts and reads back.
    req0 = 1;
    cyc(); chk("grant0 for load", grant0, 1);
    for (int i = 0; i < 8; i++) begin
      wr0 = 1; addr0 = wv[i].addr; din0 = wv[i].din;
      #1 chk($sformatf("load%0d s_addr", i), s_addr, wv[i].addr);
      cyc();
    end
    wr0 = 1; addr0 = 0; din0 = 8'hFF; start0 = 1;
    #1 chk("start pulse", {s_start, s_wr}, 2'b10);
    cyc(); start0 = 0; wr0 = 0;
    #1 chk("ack no start", {s_start, s_wr, grant0}, 3'b001);
    seen = 0;
    for (int k = 0; k < 50 && seen == 0; k++) begin
      cyc();
      if (s_start) chk("extra s_start", s_start, 0);
      if (done0) seen = 1;
    end
    chk("done0 seen", seen, 1);
    cyc(); chk("done0 one cycle", {done0, grant0}, 2'b01);
    for (int i = 0; i < 8; i++) begin
      addr0 = 3'(i);
      cyc();
      chk($sformatf("read%0d dout", i), dout, rexp[i]);
    end
    req0 = 0;
    cyc(); cyc();

    // Watchdog: owner 1 (wins tie since 0 was last served) idles while 0 waits.
    req0 = 1; req1 = 1;
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk($sformatf("wd cyc%0d revoked1", c), {revoked1, grant1}, {c == 4, 1'b1});
    end
    cyc(); chk("revoke drain", {grant0, grant1, revoked1}, 0);
    req1 = 0;
    cyc();
    cyc(); chk("grant0 after revoke", {grant0, grant1}, 2'b10);

    // Long sort: watchdog held off until back in GRANT.
    lat = 200;
    start0 = 1;
    #1 chk("long start", s_start, 1);
    cyc(); start0 = 0; req1 = 1;
    seen = 0; bad = 0;
    for (int k = 0; k < 400 && seen == 0; k++) begin
      cyc();
      if (revoked0 || revoked1 || !grant0) bad++;
      if (done0) seen = 1;
    end
    chk("long done0 seen", seen, 1);
    chk("no revoke in sort", bad, 0);
    for (int c = 1; c <= 4; c++) begin
      cyc();
      chk($sformatf("post-sort wd%0d revoked0", c), revoked0, c == 4);
    end
    cyc(); req0 = 0;
    cyc();
    cyc(); chk("grant1 after revoke", {grant0, grant1}, 2'b01);
    req1 = 0;
    cyc(); cyc();

    // Reset in the middle of a sort.
    lat = 50; req0 = 1;
    cyc(); start0 = 1;
    cyc(); start0 = 0;
    cyc();
    repeat (10) cyc();
    chk("in sort", {grant0, s_ready}, 2'b10);
    rst = 1;
    #1;
    chk("mid-sort rst grants", {grant0, grant1}, 0);
    chk("mid-sort rst pulses", {done0, done1, revoked0, revoked1}, 0);
    chk("mid-sort rst ctl", {s_start, s_wr, s_addr, s_din, s_nrst}, 0);
    req0 = 0;
    cyc(); cyc();
    rst = 0;
    bad = 0;
    for (int k = 0; k < 60; k++) begin
      cyc();
      if (done0 || done1 || grant0 || grant1) bad++;
    end
    chk("no done after rst", bad, 0);
    req0 = 1; req1 = 1;
    cyc(); chk("tie after rst", {grant0, grant1}, 2'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
